// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus structures for the L1-to-memory interface and the arbiter
// state encoding.
//
// mem_bus_req_t  : request from a cache (or to memory); valid qualifies it.
// mem_bus_resp_t : response from memory; mem_ready marks the completion beat.
// arb_state_t    : arbiter ownership state.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
  } mem_bus_req_t;

  typedef struct packed {
    logic                  mem_ready;
    logic [DATA_W-1:0]     rdata;
  } mem_bus_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares the single downstream memory bus between the instruction-side L1 (I)
// and the data-side L1 (D). The owner keeps the bus for one full transaction.
// D has fixed priority over I, but once D has been granted MAX_WAIT times in a
// row while I was waiting, I wins the next arbitration.
//
// Ports
//   clock    : sole clock, all state updates on posedge
//   reset    : synchronous, active-high
//   i_req    : I-side request (active when i_req.valid)
//   i_resp   : I-side response (only live while I owns the bus)
//   d_req    : D-side request (active when d_req.valid)
//   d_resp   : D-side response (only live while D owns the bus)
//   mem_req  : downstream request, combinational mux of the owner's request
//   mem_resp : downstream response; mem_ready ends the transaction
//   grant_i  : registered, I owns the bus
//   grant_d  : registered, D owns the bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  mem_bus_req_t  i_req,
  output mem_bus_resp_t i_resp,
  input  mem_bus_req_t  d_req,
  output mem_bus_resp_t d_resp,
  output mem_bus_req_t  mem_req,
  input  mem_bus_resp_t mem_resp,
  output logic          grant_i,
  output logic          grant_d
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_t state;
  arb_state_t state_n;
  logic [3:0] starve_cnt;
  logic       arbitrate;
  logic       i_grant;
  logic       d_grant;

  // D wins unless I has been waiting long enough; the starvation flag is
  // computed by the caller so this stays a pure priority decision.
  function automatic arb_state_t pick_winner(input logic i_valid,
                                             input logic d_valid,
                                             input logic i_starved);
    arb_state_t w;
    w = ARB_IDLE;
    if (i_valid && (!d_valid || i_starved))
      w = ARB_OWN_I;
    else if (d_valid)
      w = ARB_OWN_D;
    return w;
  endfunction

  // Next-state, arbitration point and bus muxing
  always_comb begin
    state_n   = state;
    arbitrate = 1'b0;
    mem_req   = '0;
    i_resp    = '0;
    d_resp    = '0;

    unique case (state)
      ARB_IDLE: begin
        arbitrate = 1'b1;
      end
      ARB_OWN_I: begin
        mem_req = i_req;
        i_resp  = mem_resp;
        // Dropping valid before mem_ready (e.g. cache flush) releases the
        // bus just like a completion.
        if (mem_resp.mem_ready || !i_req.valid)
          arbitrate = 1'b1;
      end
      ARB_OWN_D: begin
        mem_req = d_req;
        d_resp  = mem_resp;
        if (mem_resp.mem_ready || !d_req.valid)
          arbitrate = 1'b1;
      end
      default: begin
        state_n = ARB_IDLE;
      end
    endcase

    // Arbitrating on the completion cycle gives back-to-back handoff, and
    // the completing requester remains a candidate.
    if (arbitrate)
      state_n = pick_winner(i_req.valid, d_req.valid,
                            starve_cnt >= MAX_WAIT_C);
  end

  assign i_grant = arbitrate && (state_n == ARB_OWN_I);
  assign d_grant = arbitrate && (state_n == ARB_OWN_D);

  // State register and starvation counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_n;
      if (!i_req.valid || i_grant)
        starve_cnt <= '0;
      else if (d_grant && (starve_cnt != 4'hF))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign grant_i = (state == ARB_OWN_I);
  assign grant_d = (state == ARB_OWN_D);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, single D transaction,
// simultaneous I/D requests, starvation handoff, owner withdraw and
// reset in the middle of a transaction.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  mem_bus_req_t  i_req;
  mem_bus_resp_t i_resp;
  mem_bus_req_t  d_req;
  mem_bus_resp_t d_resp;
  mem_bus_req_t  mem_req;
  mem_bus_resp_t mem_resp;
  logic          grant_i;
  logic          grant_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.MAX_WAIT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .i_req    (i_req),
    .i_resp   (i_resp),
    .d_req    (d_req),
    .d_resp   (d_resp),
    .mem_req  (mem_req),
    .mem_resp (mem_resp),
    .grant_i  (grant_i),
    .grant_d  (grant_d)
  );

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    @(negedge clock);
  endtask

  function automatic mem_bus_req_t mk_req(input logic v, input logic [31:0] a);
    mem_bus_req_t r;
    r       = '0;
    r.valid = v;
    r.addr  = a;
    r.wdata = a ^ 32'h5A5A_0000;
    r.wstrb = 4'hF;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    i_req    = '0;
    d_req    = '0;
    mem_resp = '0;
    step;
    step;

    // 1: reset state, then idle
    settle;
    check_val("rst_grant_i", grant_i, 0);
    check_val("rst_grant_d", grant_d, 0);
    check_val("rst_starve", dut.starve_cnt, 0);
    reset = 1'b0;
    repeat (5) step;
    settle;
    check_val("idle_grant_i", grant_i, 0);
    check_val("idle_grant_d", grant_d, 0);
    check_val("idle_mem_valid", mem_req.valid, 0);
    check_val("idle_i_ready", i_resp.mem_ready, 0);
    check_val("idle_d_ready", d_resp.mem_ready, 0);

    // 2: single D transaction, mem_ready after 3 owned cycles
    step;
    d_req = mk_req(1'b1, 32'h1000);
    settle;
    check_val("t2_idle_no_mem_req", mem_req.valid, 0);
    step;
    settle;
    check_val("t2_grant_d", grant_d, 1);
    check_val("t2_grant_i", grant_i, 0);
    check_val("t2_mem_valid", mem_req.valid, 1);
    check_val("t2_mem_addr", mem_req.addr, 32'h1000);
    check_val("t2_mem_wdata", mem_req.wdata, 32'h5A5A_1000);
    check_val("t2_d_ready_early", d_resp.mem_ready, 0);
    step;
    step;
    mem_resp.mem_ready = 1'b1;
    mem_resp.rdata     = 32'hCAFE_F00D;
    d_req              = '0;
    settle;
    check_val("t2_d_ready", d_resp.mem_ready, 1);
    check_val("t2_d_rdata", d_resp.rdata, 32'hCAFE_F00D);
    check_val("t2_i_ready", i_resp.mem_ready, 0);
    check_val("t2_i_rdata", i_resp.rdata, 0);
    step;
    mem_resp = '0;
    settle;
    check_val("t2_after_grant_d", grant_d, 0);
    check_val("t2_after_grant_i", grant_i, 0);
    check_val("t2_after_d_ready", d_resp.mem_ready, 0);

    // 3: simultaneous requests, D first, then I with no bubble
    step;
    i_req = mk_req(1'b1, 32'h2000);
    d_req = mk_req(1'b1, 32'h3000);
    step;
    settle;
    check_val("t3_grant_d", grant_d, 1);
    check_val("t3_grant_i", grant_i, 0);
    check_val("t3_mem_addr_d", mem_req.addr, 32'h3000);
    step;
    mem_resp.mem_ready = 1'b1;
    mem_resp.rdata     = 32'h0000_3333;
    d_req              = '0;
    settle;
    check_val("t3_d_ready", d_resp.mem_ready, 1);
    check_val("t3_i_ready_while_d", i_resp.mem_ready, 0);
    step;
    mem_resp = '0;
    settle;
    check_val("t3_handoff_grant_i", grant_i, 1);
    check_val("t3_handoff_grant_d", grant_d, 0);
    check_val("t3_mem_addr_i", mem_req.addr, 32'h2000);
    step;
    mem_resp.mem_ready = 1'b1;
    mem_resp.rdata     = 32'h0000_2222;
    i_req              = '0;
    settle;
    check_val("t3_i_ready", i_resp.mem_ready, 1);
    check_val("t3_i_rdata", i_resp.rdata, 32'h0000_2222);
    step;
    mem_resp = '0;
    settle;
    check_val("t3_end_grant_i", grant_i, 0);
    check_val("t3_end_starve", dut.starve_cnt, 0);

    // 4: D re-requests continuously while I waits -> 4 D grants, then I
    step;
    i_req = mk_req(1'b1, 32'h4000);
    d_req = mk_req(1'b1, 32'h5000);
    step;
    for (int k = 0; k < 4; k++) begin
      settle;
      check_val($sformatf("t4_dgrant_%0d", k), grant_d, 1);
      check_val($sformatf("t4_igrant_%0d", k), grant_i, 0);
      check_val($sformatf("t4_starve_%0d", k), dut.starve_cnt, 64'(k + 1));
      step;
      mem_resp.mem_ready = 1'b1;
      step;
      mem_resp = '0;
    end
    settle;
    check_val("t4_i_wins", grant_i, 1);
    check_val("t4_d_loses", grant_d, 0);
    check_val("t4_starve_clr", dut.starve_cnt, 0);
    check_val("t4_mem_addr_i", mem_req.addr, 32'h4000);
    step;
    mem_resp.mem_ready = 1'b1;
    i_req              = '0;
    step;
    mem_resp = '0;
    settle;
    check_val("t4_d_back", grant_d, 1);

    // 5: D withdraws before mem_ready, later stray mem_ready
    step;
    d_req = '0;
    settle;
    check_val("t5_withdraw_d_ready", d_resp.mem_ready, 0);
    check_val("t5_withdraw_mem_valid", mem_req.valid, 0);
    step;
    settle;
    check_val("t5_released_d", grant_d, 0);
    check_val("t5_released_i", grant_i, 0);
    step;
    mem_resp.mem_ready = 1'b1;
    mem_resp.rdata     = 32'h0000_1234;
    settle;
    check_val("t5_stray_d_ready", d_resp.mem_ready, 0);
    check_val("t5_stray_i_ready", i_resp.mem_ready, 0);
    check_val("t5_stray_d_rdata", d_resp.rdata, 0);
    step;
    mem_resp = '0;
    settle;
    check_val("t5_stray_grant_d", grant_d, 0);
    check_val("t5_stray_grant_i", grant_i, 0);

    // 6: reset while I owns with mem_ready still pending
    step;
    i_req = mk_req(1'b1, 32'h6000);
    step;
    settle;
    check_val("t6_grant_i", grant_i, 1);
    check_val("t6_mem_valid", mem_req.valid, 1);
    step;
    reset = 1'b1;
    step;
    mem_resp.mem_ready = 1'b1;
    mem_resp.rdata     = 32'h0000_6666;
    settle;
    check_val("t6_rst_grant_i", grant_i, 0);
    check_val("t6_rst_mem_valid", mem_req.valid, 0);
    check_val("t6_rst_i_ready", i_resp.mem_ready, 0);
    reset    = 1'b0;
    i_req    = '0;
    mem_resp = '0;
    step;
    settle;
    check_val("t6_end_grant_i", grant_i, 0);
    check_val("t6_end_grant_d", grant_d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
